// File: rtl/enigma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : enigma_pkg
//  Description : Shared widths, stepper state encoding and rotor notch constants
//                for the three-rotor Enigma datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package enigma_pkg;

    localparam int LETTER_W     = 5;
    localparam int POS_W        = 6;
    localparam int ALPHABET_MAX = 25;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] STEP   = 2'd1;
    localparam logic [STATE_W-1:0] SETTLE = 2'd2;
    localparam logic [STATE_W-1:0] EMIT   = 2'd3;

    localparam logic [POS_W-1:0] NOTCH_ROTOR_I   = 6'd16;
    localparam logic [POS_W-1:0] NOTCH_ROTOR_II  = 6'd4;
    localparam logic [POS_W-1:0] NOTCH_ROTOR_III = 6'd21;

    // Out-of-alphabet positions can never sit on a notch.
    function automatic logic in_alphabet_pos(input logic [POS_W-1:0] pos);
        return pos <= POS_W'(ALPHABET_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/notch_decode.sv
`default_nettype none
// ============================================================================
//  Module      : notch_decode
//  Description : Combinational turnover decode: rotor positions to step bits,
//                including the middle-rotor double-step.
//  Revision    : 1.0 - initial release
// ============================================================================
module notch_decode
    import enigma_pkg::*;
#(
    parameter logic [POS_W-1:0] NOTCH_R = NOTCH_ROTOR_I,
    parameter logic [POS_W-1:0] NOTCH_M = NOTCH_ROTOR_II
) (
    input  logic [POS_W-1:0] i_pos_m,
    input  logic [POS_W-1:0] i_pos_r,
    output logic             o_step_l,
    output logic             o_step_m,
    output logic             o_step_r
);

    logic w_r_at_notch;
    logic w_m_at_notch;

    always_comb begin
        w_r_at_notch = in_alphabet_pos(i_pos_r) && (i_pos_r == NOTCH_R);
        w_m_at_notch = in_alphabet_pos(i_pos_m) && (i_pos_m == NOTCH_M);
        o_step_r     = 1'b1;
        // A middle rotor on its notch carries itself along with the left rotor.
        o_step_m     = w_r_at_notch || w_m_at_notch;
        o_step_l     = w_m_at_notch;
    end

endmodule
`default_nettype wire

// File: rtl/rotor_stepper.sv
`default_nettype none
// ============================================================================
//  Module      : rotor_stepper
//  Description : Key-press front end: accepts a letter, pulses the rotor steps,
//                waits for the rotors to settle, then hands the letter on.
//  Revision    : 1.0 - initial release
// ============================================================================
module rotor_stepper
    import enigma_pkg::*;
#(
    parameter logic [POS_W-1:0] NOTCH_R       = NOTCH_ROTOR_I,
    parameter logic [POS_W-1:0] NOTCH_M       = NOTCH_ROTOR_II,
    parameter int               SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                key_valid,
    input  logic [LETTER_W-1:0] key_letter,
    output logic                key_ready,
    input  logic [POS_W-1:0]    pos_l,
    input  logic [POS_W-1:0]    pos_m,
    input  logic [POS_W-1:0]    pos_r,
    output logic                step_l,
    output logic                step_m,
    output logic                step_r,
    output logic                letter_valid,
    output logic [LETTER_W-1:0] letter_out,
    input  logic                letter_ready,
    output logic                bad_key
);

    logic [STATE_W-1:0]  r_state;
    logic [STATE_W-1:0]  w_state_nxt;
    logic [2:0]          r_settle_cnt;
    logic [LETTER_W-1:0] r_letter;
    logic                r_step_l;
    logic                r_step_m;
    logic                r_step_r;
    logic                r_letter_valid;
    logic                r_bad_key;

    logic w_accept;
    logic w_letter_ok;
    logic w_dec_l;
    logic w_dec_m;
    logic w_dec_r;
    logic w_unused_pos_l;

    // The left rotor has no rotor beyond it, so its position never gates a step.
    assign w_unused_pos_l = ^pos_l;

    assign key_ready   = resetn && (r_state == IDLE);
    assign w_accept    = key_valid && key_ready;
    assign w_letter_ok = key_letter <= LETTER_W'(ALPHABET_MAX);

    notch_decode #(
        .NOTCH_R (NOTCH_R),
        .NOTCH_M (NOTCH_M)
    ) u_notch_decode (
        .i_pos_m  (pos_m),
        .i_pos_r  (pos_r),
        .o_step_l (w_dec_l),
        .o_step_m (w_dec_m),
        .o_step_r (w_dec_r)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_letter_ok) w_state_nxt = STEP;
            STEP:    w_state_nxt = SETTLE;
            SETTLE:  if (r_settle_cnt <= 3'd1) w_state_nxt = EMIT;
            EMIT:    if (r_letter_valid && letter_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Step pulses are captured from the positions present at the accept edge,
    // so they are high for exactly the STEP cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_step_l       <= 1'b0;
            r_step_m       <= 1'b0;
            r_step_r       <= 1'b0;
            r_bad_key      <= 1'b0;
            r_letter       <= '0;
            r_settle_cnt   <= 3'd0;
            r_letter_valid <= 1'b0;
        end else begin
            r_step_l  <= 1'b0;
            r_step_m  <= 1'b0;
            r_step_r  <= 1'b0;
            r_bad_key <= 1'b0;
            if (w_accept) begin
                if (w_letter_ok) begin
                    r_letter <= key_letter;
                    r_step_l <= w_dec_l;
                    r_step_m <= w_dec_m;
                    r_step_r <= w_dec_r;
                end else begin
                    r_bad_key <= 1'b1;
                end
            end
            if (r_state == STEP) begin
                r_settle_cnt <= 3'(SETTLE_CYCLES);
            end else if (r_state == SETTLE) begin
                r_settle_cnt <= r_settle_cnt - 3'd1;
            end
            // Valid rises one cycle into EMIT and falls on the handshake edge.
            r_letter_valid <= (r_state == EMIT) && !(r_letter_valid && letter_ready);
        end
    end

    assign step_l       = r_step_l;
    assign step_m       = r_step_m;
    assign step_r       = r_step_r;
    assign letter_valid = r_letter_valid;
    assign letter_out   = r_letter;
    assign bad_key      = r_bad_key;

endmodule
`default_nettype wire

// File: tb/tb_rotor_stepper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rotor_stepper
//  Description : Directed bench for rotor_stepper with a cycle-level reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rotor_stepper;

    localparam int S  = 1;
    localparam int NR = 16;
    localparam int NM = 4;

    logic       clk          = 1'b0;
    logic       resetn       = 1'b0;
    logic       key_valid    = 1'b0;
    logic [4:0] key_letter   = 5'd0;
    logic [5:0] pos_l        = 6'd0;
    logic [5:0] pos_m        = 6'd0;
    logic [5:0] pos_r        = 6'd0;
    logic       letter_ready = 1'b0;
    logic       key_ready;
    logic       step_l;
    logic       step_m;
    logic       step_r;
    logic       letter_valid;
    logic [4:0] letter_out;
    logic       bad_key;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rotor_stepper #(
        .NOTCH_R       (6'(NR)),
        .NOTCH_M       (6'(NM)),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .key_valid    (key_valid),
        .key_letter   (key_letter),
        .key_ready    (key_ready),
        .pos_l        (pos_l),
        .pos_m        (pos_m),
        .pos_r        (pos_r),
        .step_l       (step_l),
        .step_m       (step_m),
        .step_r       (step_r),
        .letter_valid (letter_valid),
        .letter_out   (letter_out),
        .letter_ready (letter_ready),
        .bad_key      (bad_key)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Reference: a key press is a timestamped transaction; outputs follow from
    // the accept cycle number and the turnover rules.
    int         cyc    = 0;
    int         prev   = 0;
    bit         m_busy = 1'b0;
    int         m_acc  = -100;
    int         m_bad  = -100;
    logic [4:0] m_letter = 5'd0;
    logic [2:0] m_steps  = 3'd0;
    bit         m_valid_before;

    function automatic logic [2:0] turnover(input int m, input int r);
        bit m_turn;
        bit r_turn;
        m_turn = (m <= 25) && (m == NM);
        r_turn = (r <= 25) && (r == NR);
        return {m_turn, m_turn || r_turn, 1'b1};
    endfunction

    always @(posedge clk) begin
        prev = cyc;
        m_valid_before = m_busy && (prev >= m_acc + 2 + S);
        cyc = cyc + 1;
        if (!resetn) begin
            m_busy = 1'b0;
            m_bad  = -100;
        end else if (!m_busy) begin
            if (key_valid) begin
                if (int'(key_letter) <= 25) begin
                    m_busy   = 1'b1;
                    m_acc    = cyc;
                    m_letter = key_letter;
                    m_steps  = turnover(int'(pos_m), int'(pos_r));
                end else begin
                    m_bad = cyc;
                end
            end
        end else if (m_valid_before && letter_ready) begin
            m_busy = 1'b0;
        end
    end

    always begin
        bit exp_v;
        @(posedge clk);
        #2;
        exp_v = m_busy && (cyc >= m_acc + 2 + S);
        chk("key_ready", key_ready, resetn && !m_busy);
        chk("steps", {step_l, step_m, step_r}, (m_busy && cyc == m_acc) ? m_steps : 3'b000);
        chk("letter_valid", letter_valid, exp_v);
        if (exp_v) chk("letter_out", letter_out, m_letter);
        chk("bad_key", bad_key, cyc == m_bad);
    end

    task automatic press(input logic [4:0] k, input logic [5:0] l, input logic [5:0] m,
                         input logic [5:0] r, input logic [2:0] exp_steps,
                         input bit exp_letter, input bit rdy);
        int lat;
        @(negedge clk);
        key_valid    = 1'b1;
        key_letter   = k;
        pos_l        = l;
        pos_m        = m;
        pos_r        = r;
        letter_ready = rdy;
        @(negedge clk);
        key_valid  = 1'b0;
        key_letter = 5'd0;
        chk("lit_steps", {step_l, step_m, step_r}, exp_steps);
        chk("lit_bad_key", bad_key, !exp_letter);
        // Moving the rotors onto their notches now must not matter.
        pos_m = 6'(NM);
        pos_r = 6'(NR);
        if (exp_letter) begin
            lat = 0;
            while (!letter_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk("lit_latency", lat, 2 + S);
            chk("lit_letter", letter_out, k);
            if (rdy) begin
                @(negedge clk);
                chk("lit_valid_drop", letter_valid, 0);
            end
        end else begin
            chk("lit_bad_ready", key_ready, 1);
            repeat (4) begin
                @(negedge clk);
                chk("lit_no_letter", letter_valid, 0);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_key_ready", key_ready, 0);
        chk("rst_outputs", {step_l, step_m, step_r, letter_valid, bad_key}, 0);
        chk("rst_letter_out", letter_out, 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("ready_after_release", key_ready, 1);

        press(5'd7,  6'd0,  6'd0,  6'd3,  3'b001, 1'b1, 1'b1);
        press(5'd0,  6'd0,  6'd0,  6'd16, 3'b011, 1'b1, 1'b1);
        press(5'd1,  6'd2,  6'd4,  6'd5,  3'b111, 1'b1, 1'b1);
        press(5'd30, 6'd0,  6'd0,  6'd0,  3'b000, 1'b0, 1'b1);
        press(5'd25, 6'd25, 6'd25, 6'd25, 3'b001, 1'b1, 1'b1);
        press(5'd12, 6'd5,  6'd40, 6'd16, 3'b011, 1'b1, 1'b1);
        press(5'd3,  6'd1,  6'd4,  6'd16, 3'b111, 1'b1, 1'b1);
        press(5'd26, 6'd0,  6'd4,  6'd16, 3'b000, 1'b0, 1'b1);

        press(5'd9,  6'd0,  6'd4,  6'd0,  3'b111, 1'b1, 1'b0);
        repeat (10) begin
            @(negedge clk);
            chk("stall_valid", letter_valid, 1);
            chk("stall_letter", letter_out, 9);
        end
        resetn = 1'b0;
        @(negedge clk);
        chk("valid_after_reset", letter_valid, 0);
        chk("ready_in_reset", key_ready, 0);
        resetn       = 1'b1;
        letter_ready = 1'b1;
        @(negedge clk);
        press(5'd20, 6'd3,  6'd0,  6'd16, 3'b011, 1'b1, 1'b1);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
